output_accumulator: RTL

- Producer end of the normalization interface. Accumulates the exponent-weighted value rows for one query, O = sum(p_k * V_k), and the softmax denominator l = sum(p_k).
- Streams one key per handshake. At end of row it presents the vector and the divisor to the vector divider, over the same vld/rdy handshake the divider consumes.
- Sits between the exponent/V-fetch stage and the vector divider.

---
 rtl/output_accumulator.sv | 121 ++++++++++++
 1 files changed

// File: rtl/output_accumulator.sv
// Accumulates O = sum(p_k * V_k) and l = sum(p_k) for one query row and hands them to the divider.
// Latency: the output is valid in the cycle after the last beat is accepted; all outputs come from registers.
// Backpressure: ready is low while a result waits; it is held until vld_out && rdy_in, then one bubble follows.
module output_accumulator #(
  parameter int VEC_LEN    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_in,
  output logic                         rdy_out,
  input  logic                         last_in,
  input  logic        [DATA_WIDTH-1:0] p_in,
  input  logic signed [DATA_WIDTH-1:0] v_in [VEC_LEN],
  output logic                         vld_out,
  input  logic                         rdy_in,
  output logic signed [DATA_WIDTH-1:0] vec_out [VEC_LEN],
  output logic        [DATA_WIDTH-1:0] divisor_out
);

  typedef enum logic {ACCUM, EMIT} state_t;

  // Clamp bounds for the signed vector elements, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SMAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state_q, state_d;
  logic signed [ACC_WIDTH-1:0]    acc_q [VEC_LEN];
  logic signed [ACC_WIDTH-1:0]    acc_d [VEC_LEN];
  logic        [ACC_WIDTH-1:0]    lsum_q, lsum_d;
  logic signed [DATA_WIDTH-1:0]   vec_q [VEC_LEN];
  logic signed [DATA_WIDTH-1:0]   vec_d [VEC_LEN];
  logic        [DATA_WIDTH-1:0]   div_q, div_d;
  logic signed [ACC_WIDTH-1:0]    prod [VEC_LEN];

  function automatic logic signed [DATA_WIDTH-1:0] sat_s(input logic signed [ACC_WIDTH-1:0] a);
    if (a > SMAX)      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (a < SMIN) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else               return a[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat_u(input logic [ACC_WIDTH-1:0] a);
    if (|a[ACC_WIDTH-1:DATA_WIDTH]) return {DATA_WIDTH{1'b1}};
    else                            return a[DATA_WIDTH-1:0];
  endfunction

  // Weighted products: p is unsigned so it is zero-extended, v is sign-extended; the exact
  // product fits in 2*DATA_WIDTH+1 bits, so the truncated-to-ACC_WIDTH result is exact.
  always_comb begin
    for (int i = 0; i < VEC_LEN; i++) begin
      prod[i] = $signed({{(ACC_WIDTH-DATA_WIDTH){1'b0}}, p_in})
              * $signed({{(ACC_WIDTH-DATA_WIDTH){v_in[i][DATA_WIDTH-1]}}, v_in[i]});
    end
  end

  // Next-state and datapath: accumulate in ACCUM, snapshot saturated outputs on the last beat,
  // wait in EMIT until the divider takes the result, then clear the sums.
  always_comb begin
    state_d = state_q;
    lsum_d  = lsum_q;
    div_d   = div_q;
    for (int i = 0; i < VEC_LEN; i++) begin
      acc_d[i] = acc_q[i];
      vec_d[i] = vec_q[i];
    end
    unique case (state_q)
      ACCUM: begin
        if (vld_in) begin
          for (int i = 0; i < VEC_LEN; i++) acc_d[i] = acc_q[i] + prod[i];
          lsum_d = lsum_q + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, p_in};
          if (last_in) begin
            for (int i = 0; i < VEC_LEN; i++) vec_d[i] = sat_s(acc_d[i]);
            div_d   = sat_u(lsum_d);
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (rdy_in) begin
          for (int i = 0; i < VEC_LEN; i++) acc_d[i] = '0;
          lsum_d  = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, sums and output registers; reset discards any partial row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      lsum_q  <= '0;
      div_q   <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        acc_q[i] <= '0;
        vec_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lsum_q  <= lsum_d;
      div_q   <= div_d;
      for (int i = 0; i < VEC_LEN; i++) begin
        acc_q[i] <= acc_d[i];
        vec_q[i] <= vec_d[i];
      end
    end
  end

  // Handshake outputs depend only on the registered state.
  always_comb begin
    rdy_out     = (state_q == ACCUM);
    vld_out     = (state_q == EMIT);
    divisor_out = div_q;
    for (int i = 0; i < VEC_LEN; i++) vec_out[i] = vec_q[i];
  end

endmodule
